// File: rtl/adxl355_pkg.sv
// Shared constants and state encoding for the ADXL355 sequencing controller.
package adxl355_pkg;

    localparam logic [6:0] ADDR_DEVID_AD  = 7'h00;
    localparam logic [6:0] ADDR_STATUS    = 7'h04;
    localparam logic [6:0] ADDR_XDATA3    = 7'h08;
    localparam logic [6:0] ADDR_FILTER    = 7'h28;
    localparam logic [6:0] ADDR_RANGE     = 7'h2C;
    localparam logic [6:0] ADDR_POWER_CTL = 7'h2D;
    localparam logic [6:0] ADDR_RESET     = 7'h2F;

    localparam logic [7:0] RESET_CODE   = 8'h52;
    localparam logic [7:0] DEVID_AD_VAL = 8'hAD;
    localparam logic [3:0] XYZ_LEN      = 4'd9;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SRST,
        S_WAIT_BOOT,
        S_ID,
        S_CFG_RANGE,
        S_CFG_FILTER,
        S_CFG_POWER,
        S_POLL_WAIT,
        S_POLL,
        S_READ_XYZ,
        S_ERROR
    } state_t;

endpackage

// File: rtl/adxl355_sample_unpack.sv
// Counts burst bytes and assembles XDATA3..ZDATA1 into three 20-bit staging words.
module adxl355_sample_unpack
    import adxl355_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_byte_vld,
    input  logic [7:0]  i_byte,
    output logic [3:0]  o_count,
    output logic [19:0] o_x,
    output logic [19:0] o_y,
    output logic [19:0] o_z
);

    logic [3:0]  r_count;
    logic [19:0] r_x;
    logic [19:0] r_y;
    logic [19:0] r_z;

    // Counter saturates so an overlong burst can never wrap back to a valid length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_byte_vld) begin
            if (r_count != 4'hF) begin
                r_count <= r_count + 4'd1;
            end
            case (r_count)
                4'd0:    r_x[19:12] <= i_byte;
                4'd1:    r_x[11:4]  <= i_byte;
                4'd2:    r_x[3:0]   <= i_byte[7:4];
                4'd3:    r_y[19:12] <= i_byte;
                4'd4:    r_y[11:4]  <= i_byte;
                4'd5:    r_y[3:0]   <= i_byte[7:4];
                4'd6:    r_z[19:12] <= i_byte;
                4'd7:    r_z[11:4]  <= i_byte;
                4'd8:    r_z[3:0]   <= i_byte[7:4];
                default: ;
            endcase
        end
    end

    assign o_count = (r_count == XYZ_LEN) ? XYZ_LEN : r_count;
    assign o_x     = r_x;
    assign o_y     = r_y;
    assign o_z     = r_z;

endmodule

// File: rtl/adxl355_ctrl.sv
// ADXL355 power-up sequencer and data poller driving spi_master.
// Define ADXL355_ID_CHECK_EN to include the DEVID_AD identity check after boot.
module adxl355_ctrl
    import adxl355_pkg::*;
#(
    parameter logic [7:0] RANGE_VAL  = 8'h01,
    parameter logic [7:0] FILTER_VAL = 8'h00,
    parameter int         BOOT_WAIT  = 5000,
    parameter int         POLL_DIV   = 500,
    parameter int         TIMEOUT    = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        spi_start,
    output logic        spi_wr_rd,
    output logic [6:0]  spi_addr,
    output logic [7:0]  spi_wdata,
    output logic [3:0]  spi_len,
    input  logic [7:0]  spi_rdata,
    input  logic        spi_rdata_vld,
    input  logic        spi_done,
    output logic [19:0] sample_x,
    output logic [19:0] sample_y,
    output logic [19:0] sample_z,
    output logic        sample_vld,
    output logic        cfg_done,
    output logic        err
);

    localparam int WAIT_MAX = (BOOT_WAIT > POLL_DIV) ? BOOT_WAIT : POLL_DIV;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam int WDOG_W   = $clog2(TIMEOUT + 1);

    state_t              r_state;
    state_t              w_next;
    logic                r_busy;
    logic [WAIT_W-1:0]   r_cnt;
    logic [WDOG_W-1:0]   r_wdog;
    logic [7:0]          r_rx;
    logic                w_issue;
    logic                w_done;
    logic                w_timeout;
    logic                w_rx_cap;
    logic                w_cmd_wr;
    logic [6:0]          w_cmd_addr;
    logic [7:0]          w_cmd_wdata;
    logic [3:0]          w_cmd_len;
    logic [3:0]          w_count;
    logic [19:0]         w_x;
    logic [19:0]         w_y;
    logic [19:0]         w_z;

    assign w_done    = spi_done && r_busy;
    assign w_timeout = r_busy && !spi_done && (r_wdog == WDOG_W'(TIMEOUT - 1));

    adxl355_sample_unpack u_unpack (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_issue && (r_state == S_READ_XYZ)),
        .i_byte_vld (spi_rdata_vld && r_busy && (r_state == S_READ_XYZ)),
        .i_byte     (spi_rdata),
        .o_count    (w_count),
        .o_x        (w_x),
        .o_y        (w_y),
        .o_z        (w_z)
    );

    // Transaction states issue once when idle, then advance on the matching spi_done.
    always_comb begin
        w_next      = r_state;
        w_issue     = 1'b0;
        w_cmd_wr    = 1'b0;
        w_cmd_addr  = '0;
        w_cmd_wdata = '0;
        w_cmd_len   = 4'd1;
        case (r_state)
            S_IDLE: begin
                if (enable) w_next = cfg_done ? S_POLL_WAIT : S_SRST;
            end
            S_SRST: begin
                w_cmd_addr  = ADDR_RESET;
                w_cmd_wdata = RESET_CODE;
                w_issue     = !r_busy;
                if (w_done) w_next = S_WAIT_BOOT;
            end
            S_WAIT_BOOT: begin
                if (r_cnt == WAIT_W'(BOOT_WAIT - 1)) begin
`ifdef ADXL355_ID_CHECK_EN
                    w_next = S_ID;
`else
                    w_next = S_CFG_RANGE;
`endif
                end
            end
`ifdef ADXL355_ID_CHECK_EN
            S_ID: begin
                w_cmd_wr   = 1'b1;
                w_cmd_addr = ADDR_DEVID_AD;
                w_issue    = !r_busy;
                if (w_done) w_next = (r_rx == DEVID_AD_VAL) ? S_CFG_RANGE : S_ERROR;
            end
`endif
            S_CFG_RANGE: begin
                w_cmd_addr  = ADDR_RANGE;
                w_cmd_wdata = RANGE_VAL;
                w_issue     = !r_busy;
                if (w_done) w_next = S_CFG_FILTER;
            end
            S_CFG_FILTER: begin
                w_cmd_addr  = ADDR_FILTER;
                w_cmd_wdata = FILTER_VAL;
                w_issue     = !r_busy;
                if (w_done) w_next = S_CFG_POWER;
            end
            S_CFG_POWER: begin
                w_cmd_addr = ADDR_POWER_CTL;
                w_issue    = !r_busy;
                if (w_done) w_next = S_POLL_WAIT;
            end
            S_POLL_WAIT: begin
                if (!enable) w_next = S_IDLE;
                else if (r_cnt == WAIT_W'(POLL_DIV - 1)) w_next = S_POLL;
            end
            S_POLL: begin
                w_cmd_wr   = 1'b1;
                w_cmd_addr = ADDR_STATUS;
                w_issue    = !r_busy && enable;
                if (!r_busy && !enable) w_next = S_IDLE;
                else if (w_done) w_next = r_rx[0] ? S_READ_XYZ : S_POLL_WAIT;
            end
            S_READ_XYZ: begin
                w_cmd_wr   = 1'b1;
                w_cmd_addr = ADDR_XDATA3;
                w_cmd_len  = XYZ_LEN;
                w_issue    = !r_busy;
                if (w_done) w_next = (w_count == XYZ_LEN) ? S_POLL_WAIT : S_ERROR;
            end
            default: ;
        endcase
        if (w_timeout) w_next = S_ERROR;
    end

    always_comb begin
        w_rx_cap = spi_rdata_vld && r_busy && (r_state == S_POLL);
`ifdef ADXL355_ID_CHECK_EN
        if (spi_rdata_vld && r_busy && (r_state == S_ID)) w_rx_cap = 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Command fields latch with the start pulse and stay put until the next command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spi_start <= 1'b0;
            spi_wr_rd <= 1'b0;
            spi_addr  <= '0;
            spi_wdata <= '0;
            spi_len   <= '0;
            r_busy    <= 1'b0;
            r_wdog    <= '0;
        end else begin
            spi_start <= w_issue;
            if (w_issue) begin
                spi_wr_rd <= w_cmd_wr;
                spi_addr  <= w_cmd_addr;
                spi_wdata <= w_cmd_wdata;
                spi_len   <= w_cmd_len;
                r_busy    <= 1'b1;
                r_wdog    <= '0;
            end else if (r_busy) begin
                if (spi_done || w_timeout) r_busy <= 1'b0;
                else                       r_wdog <= r_wdog + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_rx       <= '0;
            sample_x   <= '0;
            sample_y   <= '0;
            sample_z   <= '0;
            sample_vld <= 1'b0;
            cfg_done   <= 1'b0;
            err        <= 1'b0;
        end else begin
            r_cnt      <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
            sample_vld <= 1'b0;
            if (w_rx_cap) r_rx <= spi_rdata;
            if ((r_state == S_READ_XYZ) && w_done && (w_count == XYZ_LEN)) begin
                sample_x   <= w_x;
                sample_y   <= w_y;
                sample_z   <= w_z;
                sample_vld <= 1'b1;
            end
            if ((r_state == S_CFG_POWER) && w_done) cfg_done <= 1'b1;
            if (w_next == S_ERROR) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_adxl355_ctrl.sv
// Self-checking bench for adxl355_ctrl with a behavioural spi_master model and randomized bursts.
module tb_adxl355_ctrl;

   localparam int BOOT_WAIT = 20;
   localparam int POLL_DIV  = 10;
   localparam int TIMEOUT   = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        spi_start;
   logic        spi_wr_rd;
   logic [6:0]  spi_addr;
   logic [7:0]  spi_wdata;
   logic [3:0]  spi_len;
   logic [7:0]  spi_rdata;
   logic        spi_rdata_vld;
   logic        spi_done;
   logic [19:0] sample_x;
   logic [19:0] sample_y;
   logic [19:0] sample_z;
   logic        sample_vld;
   logic        cfg_done;
   logic        err;

   int          checkCount = 0;
   int          passCount = 0;
   int          sampleCount = 0;
   logic [15:0] cmdQ[$];
   logic [7:0]  statusQ[$];
   logic [7:0]  burstData[9];
   int          burstBytes;
   logic        withholdDone;
   logic [7:0]  devIdResp;
   logic        inBurst = 1'b0;
   logic [19:0] expX, expY, expZ;

   adxl355_ctrl #(
      .BOOT_WAIT (BOOT_WAIT),
      .POLL_DIV  (POLL_DIV),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .spi_start     (spi_start),
      .spi_wr_rd     (spi_wr_rd),
      .spi_addr      (spi_addr),
      .spi_wdata     (spi_wdata),
      .spi_len       (spi_len),
      .spi_rdata     (spi_rdata),
      .spi_rdata_vld (spi_rdata_vld),
      .spi_done      (spi_done),
      .sample_x      (sample_x),
      .sample_y      (sample_y),
      .sample_z      (sample_z),
      .sample_vld    (sample_vld),
      .cfg_done      (cfg_done),
      .err           (err)
   );

   always #5 clk = ~clk;

   // Every comparison in the bench funnels through here.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
   endtask

   // A 20-bit axis value is the top 20 bits of its three big-endian bytes.
   function automatic logic [19:0] axisVal(input logic [7:0] hi, input logic [7:0] mid, input logic [7:0] lo);
      int v;
      v = int'(hi) * 4096 + int'(mid) * 16 + int'(lo) / 16;
      return 20'(v);
   endfunction

   // Loads the sensor model: notReady STATUS replies with DATA_RDY clear, then one ready, then the burst.
   task automatic applyStimulus(input int notReady, input logic [71:0] bytes);
      statusQ.delete();
      for (int i = 0; i < notReady; i++) statusQ.push_back(8'($urandom()) & 8'hFE);
      statusQ.push_back(8'($urandom()) | 8'h01);
      for (int i = 0; i < 9; i++) burstData[i] = bytes[71 - 8*i -: 8];
      expX = axisVal(burstData[0], burstData[1], burstData[2]);
      expY = axisVal(burstData[3], burstData[4], burstData[5]);
      expZ = axisVal(burstData[6], burstData[7], burstData[8]);
   endtask

   function automatic logic [71:0] randBytes();
      return {8'($urandom()), 32'($urandom()), 32'($urandom())};
   endfunction

   // Behavioural spi_master: records each command, returns bytes, then pulses done.
   task automatic serveTxn();
      logic       wr;
      logic [6:0] a;
      logic [7:0] d;
      logic [7:0] b;
      logic [3:0] n;
      int         nb;
      wr = spi_wr_rd; a = spi_addr; d = spi_wdata; n = spi_len;
      cmdQ.push_back({wr, a, wr ? 8'h00 : d});
      checkOutput("txnLen", 32'(n), (wr && a == 7'h08) ? 32'd9 : 32'd1);
      nb = 0;
      if (wr) nb = (a == 7'h08) ? burstBytes : 1;
      inBurst = wr && (a == 7'h08);
      @(negedge clk);
      checkOutput("startPulseWidth", 32'(spi_start), 32'd0);
      for (int i = 0; i < nb && !rst; i++) begin
         if (a == 7'h04) b = (statusQ.size() > 0) ? statusQ.pop_front() : 8'h00;
         else if (a == 7'h00) b = devIdResp;
         else b = burstData[i];
         spi_rdata = b;
         spi_rdata_vld = 1'b1;
         @(negedge clk);
         spi_rdata_vld = 1'b0;
         @(negedge clk);
      end
      if (!rst) checkOutput("cmdHeld", 32'({spi_wr_rd, spi_addr}), 32'({wr, a}));
      if (!withholdDone && !rst) begin
         spi_done = 1'b1;
         @(negedge clk);
         spi_done = 1'b0;
      end
      inBurst = 1'b0;
   endtask

   initial begin
      spi_rdata = 8'h00;
      spi_rdata_vld = 1'b0;
      spi_done = 1'b0;
      forever begin
         @(negedge clk);
         if (spi_start && !rst) serveTxn();
      end
   end

   always @(negedge clk) if (sample_vld) sampleCount++;

   task automatic waitSamples(input int target, input int budget, input string tag);
      int c = 0;
      while (sampleCount < target && c < budget) begin
         @(negedge clk);
         c++;
      end
      checkOutput(tag, 32'(sampleCount >= target), 32'd1);
   endtask

   task automatic waitInBurst(input string tag);
      int c = 0;
      while (!inBurst && c < 500) begin
         @(negedge clk);
         c++;
      end
      checkOutput(tag, 32'(inBurst), 32'd1);
   endtask

   task automatic checkSamples(input string tag);
      checkOutput({tag, "X"}, 32'(sample_x), 32'(expX));
      checkOutput({tag, "Y"}, 32'(sample_y), 32'(expY));
      checkOutput({tag, "Z"}, 32'(sample_z), 32'(expZ));
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "Ctl"}, 32'({spi_start, spi_wr_rd, spi_addr, spi_wdata, spi_len, sample_vld, cfg_done, err}), 32'd0);
      checkOutput({tag, "Samples"}, 32'(sample_x | sample_y | sample_z), 32'd0);
   endtask

   // Expected command stream: optional power-up sequence, then polls ending in one burst read.
   task automatic checkCmds(input string tag, input int notReady, input bit withCfg);
      logic [15:0] exp[$];
      if (withCfg) begin
         exp.push_back({1'b0, 7'h2F, 8'h52});
`ifdef ADXL355_ID_CHECK_EN
         exp.push_back({1'b1, 7'h00, 8'h00});
`endif
         exp.push_back({1'b0, 7'h2C, 8'h01});
         exp.push_back({1'b0, 7'h28, 8'h00});
         exp.push_back({1'b0, 7'h2D, 8'h00});
      end
      for (int i = 0; i <= notReady; i++) exp.push_back({1'b1, 7'h04, 8'h00});
      exp.push_back({1'b1, 7'h08, 8'h00});
      checkOutput({tag, "Count"}, 32'(cmdQ.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size() && i < cmdQ.size(); i++)
         checkOutput(tag, 32'(cmdQ[i]), 32'(exp[i]));
   endtask

   initial begin
      int          nr;
      int          c;
      int          seenCmds;
      logic [19:0] savedX, savedY, savedZ;

      rst = 1'b1;
      enable = 1'b0;
      withholdDone = 1'b0;
      burstBytes = 9;
      devIdResp = 8'hAD;
      repeat (3) @(negedge clk);
      checkAllZero("reset");

      $display("[TB] power-up, configuration and first sample");
      applyStimulus(2, 72'h12345F_80000F_FFFFF0);
      rst = 1'b0;
      enable = 1'b1;
      waitSamples(1, 3000, "firstSample");
      checkCmds("cfgSeq", 2, 1'b1);
      checkOutput("cfgDone", 32'(cfg_done), 32'd1);
      checkOutput("errClear", 32'(err), 32'd0);
      checkSamples("fixed");

      $display("[TB] randomized polling rounds");
      for (int r = 0; r < 4; r++) begin
         cmdQ.delete();
         nr = $urandom_range(0, 2);
         applyStimulus(nr, randBytes());
         waitSamples(sampleCount + 1, 1000, "randSample");
         checkCmds("randPoll", nr, 1'b0);
         checkSamples("rand");
      end

      $display("[TB] enable dropped mid-burst");
      cmdQ.delete();
      applyStimulus(0, randBytes());
      waitInBurst("dropBurstSeen");
      enable = 1'b0;
      waitSamples(sampleCount + 1, 500, "dropSample");
      checkSamples("drop");
      repeat (5 * POLL_DIV) @(negedge clk);
      checkOutput("idleNoStart", 32'(cmdQ.size()), 32'd2);
      cmdQ.delete();
      applyStimulus(1, randBytes());
      enable = 1'b1;
      waitSamples(sampleCount + 1, 1000, "resumeSample");
      checkCmds("resumePoll", 1, 1'b0);
      checkSamples("resume");
      checkOutput("cfgDoneKept", 32'(cfg_done), 32'd1);

      $display("[TB] short burst");
      savedX = expX; savedY = expY; savedZ = expZ;
      nr = sampleCount;
      burstBytes = 6;
      applyStimulus(0, randBytes());
      c = 0;
      while (!err && c < 1000) begin
         @(negedge clk);
         c++;
      end
      checkOutput("shortErr", 32'(err), 32'd1);
      checkOutput("shortNoVld", 32'(sampleCount), 32'(nr));
      checkOutput("shortKeepX", 32'(sample_x), 32'(savedX));
      checkOutput("shortKeepY", 32'(sample_y), 32'(savedY));
      checkOutput("shortKeepZ", 32'(sample_z), 32'(savedZ));
      seenCmds = cmdQ.size();
      repeat (100) @(negedge clk);
      checkOutput("errNoStart", 32'(cmdQ.size()), 32'(seenCmds));

      $display("[TB] watchdog");
      rst = 1'b1;
      burstBytes = 9;
      withholdDone = 1'b1;
      @(negedge clk);
      checkAllZero("reset2");
      cmdQ.delete();
      rst = 1'b0;
      c = 0;
      while (!spi_start && c < 50) begin
         @(negedge clk);
         c++;
      end
      checkOutput("wdogStart", 32'(spi_start), 32'd1);
      c = 0;
      while (!err && c < TIMEOUT + 20) begin
         @(negedge clk);
         c++;
      end
      checkOutput("wdogCycles", 32'(c), 32'(TIMEOUT));
      repeat (100) @(negedge clk);
      checkOutput("wdogNoStart", 32'(cmdQ.size()), 32'd1);

`ifdef ADXL355_ID_CHECK_EN
      $display("[TB] DEVID mismatch");
      rst = 1'b1;
      withholdDone = 1'b0;
      devIdResp = 8'h3C;
      @(negedge clk);
      cmdQ.delete();
      rst = 1'b0;
      c = 0;
      while (!err && c < BOOT_WAIT + 300) begin
         @(negedge clk);
         c++;
      end
      checkOutput("idErr", 32'(err), 32'd1);
      repeat (100) @(negedge clk);
      checkOutput("idNoStart", 32'(cmdQ.size()), 32'd2);
      devIdResp = 8'hAD;
`endif

      $display("[TB] reset mid-burst");
      rst = 1'b1;
      withholdDone = 1'b0;
      @(negedge clk);
      cmdQ.delete();
      applyStimulus(0, randBytes());
      rst = 1'b0;
      waitSamples(sampleCount + 1, 3000, "reconfigSample");
      checkSamples("reconfig");
      applyStimulus(0, randBytes());
      waitInBurst("rstBurstSeen");
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkAllZero("midBurstReset");
      rst = 1'b0;
      enable = 1'b0;
      repeat (5) @(negedge clk);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
